// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared types, field positions and opcode constants for the decode stage
package decode_pkg;

  // Instruction class carried in bits [31:30]
  typedef enum logic [1:0] {
    FT_REG    = 2'b00,
    FT_MEM    = 2'b01,
    FT_BRANCH = 2'b10,
    FT_KERNEL = 2'b11
  } funtype_e;

  // Stage occupancy; HAZARD is the single bubble cycle after a load-use stall
  typedef enum logic [1:0] {
    ST_EMPTY  = 2'b00,
    ST_FULL   = 2'b01,
    ST_HAZARD = 2'b10
  } state_e;

  // Function codes within each class
  localparam logic [1:0] FC_REG_MOV     = 2'b10;
  localparam logic [1:0] FC_REG_CMP     = 2'b11;
  localparam logic [1:0] FC_MEM_LOAD    = 2'b00;
  localparam logic [1:0] FC_MEM_STORE   = 2'b01;
  localparam logic [1:0] FC_KER_CACHEWR = 2'b01;
  localparam logic [1:0] FC_KER_CACHESH = 2'b10;

  // Field bit positions
  localparam int FT_MSB  = 31;
  localparam int FT_LSB  = 30;
  localparam int FC_MSB  = 29;
  localparam int FC_LSB  = 28;
  localparam int RD_MSB  = 27;
  localparam int RD_LSB  = 24;
  localparam int RS_MSB  = 23;
  localparam int RS_LSB  = 20;
  localparam int RX_MSB  = 19;
  localparam int RX_LSB  = 16;
  localparam int SEL_IMM = 0;
  localparam int IMM28_W = 28;
  localparam int IMM19_W = 19;
  localparam int IMM4_W  = 4;

  // Compare is the only op that takes operand A from the rd field
  function automatic logic src_a_from_rd(input funtype_e ft, input logic [1:0] fc);
    return (ft == FT_REG) && (fc == FC_REG_CMP);
  endfunction

  // MOV and every kernel op present a zero A operand
  function automatic logic opa_forced_zero(input funtype_e ft, input logic [1:0] fc);
    return (ft == FT_KERNEL) || ((ft == FT_REG) && (fc == FC_REG_MOV));
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// rtl/decode_regfile.sv - NREGS x WIDTH register file, 3 async reads, 1 sync write, optional DECODE_FWD_EN bypass
module decode_regfile
  import decode_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [3:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [3:0]       a_addr,
  output logic [WIDTH-1:0] a_data,
  input  logic [3:0]       b_addr,
  output logic [WIDTH-1:0] b_data,
  input  logic [3:0]       s_addr,
  output logic [WIDTH-1:0] s_data
);

  logic [WIDTH-1:0] mem [NREGS];

  // Indices beyond NREGS read as zero; with DECODE_FWD_EN a same-cycle write is passed through
  function automatic logic [WIDTH-1:0] read_port(input logic [3:0] addr);
    logic [WIDTH-1:0] v;
    v = '0;
    if (int'(addr) < NREGS) v = mem[addr];
`ifdef DECODE_FWD_EN
    if (we && (waddr == addr) && (int'(addr) < NREGS)) v = wdata;
`else
`endif
    return v;
  endfunction

  assign a_data = read_port(a_addr);
  assign b_data = read_port(b_addr);
  assign s_data = read_port(s_addr);

  // Storage: cleared on reset, written on wb_we at the rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && (int'(waddr) < NREGS)) begin
      mem[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - single-entry decode stage with load-use stall and flush; DECODE_FWD_EN enables writeback bypass
module decode_stage
  import decode_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NREGS   = 16,
  parameter int PC_REG  = 14,
  parameter int BR_SEXT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] pc_in,
  input  logic             wb_we,
  input  logic [3:0]       wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] opa,
  output logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] str_data,
  output logic [WIDTH-1:0] pc_out,
  output logic [3:0]       rd_out,
  output logic [1:0]       funtype,
  output logic [1:0]       funcode,
  output logic             sel_wb,
  output logic             sel_memrd,
  output logic             sel_memwr,
  output logic             sel_cachewr,
  output logic             sel_cachesh,
  output logic             sel_branch,
  output logic             hazard
);

  localparam logic [3:0] PC_IDX = 4'(PC_REG);

  state_e state, next_state;
  logic   load;

  funtype_e   f_type;
  logic [1:0] f_code;
  logic [3:0] f_rd, f_rs, f_rx, src_a;
  logic       f_selimm;

  logic [WIDTH-1:0] imm, a_raw, b_raw, s_raw, a_val, b_val, s_val;
  logic [WIDTH-1:0] n_opa, n_opb;
  logic             n_wb, n_memrd, n_memwr, n_cachewr, n_cachesh, n_branch;

  assign f_type   = funtype_e'(instr[FT_MSB:FT_LSB]);
  assign f_code   = instr[FC_MSB:FC_LSB];
  assign f_rd     = instr[RD_MSB:RD_LSB];
  assign f_rs     = instr[RS_MSB:RS_LSB];
  assign f_rx     = instr[RX_MSB:RX_LSB];
  assign f_selimm = instr[SEL_IMM];
  assign src_a    = src_a_from_rd(f_type, f_code) ? f_rd : f_rs;

  decode_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (wb_we),
    .waddr  (wb_addr),
    .wdata  (wb_data),
    .a_addr (src_a),
    .a_data (a_raw),
    .b_addr (f_rx),
    .b_data (b_raw),
    .s_addr (f_rd),
    .s_data (s_raw)
  );

  // The PC register index reads back the PC of the instruction being decoded
  assign a_val = (src_a == PC_IDX) ? pc_in : a_raw;
  assign b_val = (f_rx  == PC_IDX) ? pc_in : b_raw;
  assign s_val = (f_rd  == PC_IDX) ? pc_in : s_raw;

  // Immediate selection by class; only branch offsets may be sign-extended
  always_comb begin
    imm = '0;
    case (f_type)
      FT_BRANCH: begin
        imm[IMM28_W-1:0] = instr[IMM28_W-1:0];
        if ((BR_SEXT != 0) && instr[IMM28_W-1]) begin
          for (int i = IMM28_W; i < WIDTH; i++) imm[i] = 1'b1;
        end
      end
      FT_REG:  imm[IMM19_W-1:0] = instr[IMM19_W:1];
      default: imm[IMM4_W-1:0]  = instr[RS_MSB:RS_LSB];
    endcase
  end

  // Operand and control values for the instruction at the input
  always_comb begin
    n_opa     = opa_forced_zero(f_type, f_code) ? '0 : a_val;
    n_opb     = f_selimm ? imm : b_val;
    n_wb      = 1'b0;
    n_memrd   = 1'b0;
    n_memwr   = 1'b0;
    n_cachewr = 1'b0;
    n_cachesh = 1'b0;
    n_branch  = 1'b0;
    case (f_type)
      FT_REG:    n_wb = (f_code != FC_REG_CMP);
      FT_MEM: begin
        n_wb    = (f_code == FC_MEM_LOAD);
        n_memrd = (f_code == FC_MEM_LOAD);
        n_memwr = (f_code == FC_MEM_STORE);
      end
      FT_BRANCH: begin
        n_wb     = 1'b1;
        n_branch = 1'b1;
      end
      default: begin
        n_wb      = ~f_code[0];
        n_cachewr = (f_code == FC_KER_CACHEWR);
        n_cachesh = (f_code == FC_KER_CACHESH);
      end
    endcase
  end

  assign out_valid = (state == ST_FULL);

  // A load in the output register whose rd feeds the next instruction must not be bypassed
  assign hazard = out_valid && sel_memrd && in_valid &&
                  ((rd_out == src_a) || (!f_selimm && (rd_out == f_rx)));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= next_state;
  end

  // Next-state and accept decision; flush overrides everything else
  always_comb begin
    next_state = state;
    load       = 1'b0;
    in_ready   = (!out_valid || out_ready) && !hazard;
    if (flush) begin
      next_state = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY, ST_HAZARD: begin
          if (in_valid) begin
            load       = 1'b1;
            next_state = ST_FULL;
          end else begin
            next_state = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            if (hazard) begin
              next_state = ST_HAZARD;
            end else if (in_valid) begin
              load       = 1'b1;
              next_state = ST_FULL;
            end else begin
              next_state = ST_EMPTY;
            end
          end
        end
        default: next_state = ST_EMPTY;
      endcase
    end
  end

  // Output register: captures on accept, otherwise holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa         <= '0;
      opb         <= '0;
      str_data    <= '0;
      pc_out      <= '0;
      rd_out      <= '0;
      funtype     <= '0;
      funcode     <= '0;
      sel_wb      <= 1'b0;
      sel_memrd   <= 1'b0;
      sel_memwr   <= 1'b0;
      sel_cachewr <= 1'b0;
      sel_cachesh <= 1'b0;
      sel_branch  <= 1'b0;
    end else if (load) begin
      opa         <= n_opa;
      opb         <= n_opb;
      str_data    <= s_val;
      pc_out      <= pc_in;
      rd_out      <= f_rd;
      funtype     <= f_type;
      funcode     <= f_code;
      sel_wb      <= n_wb;
      sel_memrd   <= n_memrd;
      sel_memwr   <= n_memwr;
      sel_cachewr <= n_cachewr;
      sel_cachesh <= n_cachesh;
      sel_branch  <= n_branch;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed and randomized checks of decode_stage against a behavioural model
module tb_decode_stage;

  localparam int W       = 32;
  localparam int PC_REG  = 14;
  localparam int BR_SEXT = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [31:0]   instr;
  logic [W-1:0]  pc_in;
  logic          wb_we;
  logic [3:0]    wb_addr;
  logic [W-1:0]  wb_data;
  logic          flush;
  logic          out_valid, out_ready;
  logic [W-1:0]  opa, opb, str_data, pc_out;
  logic [3:0]    rd_out;
  logic [1:0]    funtype, funcode;
  logic          sel_wb, sel_memrd, sel_memwr, sel_cachewr, sel_cachesh, sel_branch;
  logic          hazard;

  decode_stage #(
    .WIDTH   (W),
    .NREGS   (16),
    .PC_REG  (PC_REG),
    .BR_SEXT (BR_SEXT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instr       (instr),
    .pc_in       (pc_in),
    .wb_we       (wb_we),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .opa         (opa),
    .opb         (opb),
    .str_data    (str_data),
    .pc_out      (pc_out),
    .rd_out      (rd_out),
    .funtype     (funtype),
    .funcode     (funcode),
    .sel_wb      (sel_wb),
    .sel_memrd   (sel_memrd),
    .sel_memwr   (sel_memwr),
    .sel_cachewr (sel_cachewr),
    .sel_cachesh (sel_cachesh),
    .sel_branch  (sel_branch),
    .hazard      (hazard)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] opa, opb, str, pc;
    logic [3:0]  rd;
    logic [1:0]  ft, fc;
    logic [5:0]  ctrl;   // wb, memrd, memwr, cachewr, cachesh, branch
  } exp_t;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] regs [16];
  exp_t        e;
  logic        exp_valid;
  logic [31:0] held;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    tests++;
    assert (obs === want)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic logic [31:0] mread(input int idx, input logic [31:0] pc);
    if (idx == PC_REG) return pc;
`ifdef DECODE_FWD_EN
    if (wb_we && int'(wb_addr) == idx) return wb_data;
`endif
    return regs[idx];
  endfunction

  function automatic int src_a_of(input logic [31:0] ins);
    int ft, fc;
    ft = int'(ins >> 30);
    fc = int'((ins >> 28) & 3);
    return (ft == 0 && fc == 3) ? int'((ins >> 24) & 15) : int'((ins >> 20) & 15);
  endfunction

  function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] pc);
    exp_t r;
    int ft, fc, rd, rx;
    logic [31:0] imm;
    ft = int'(ins >> 30);
    fc = int'((ins >> 28) & 3);
    rd = int'((ins >> 24) & 15);
    rx = int'((ins >> 16) & 15);
    if (ft == 2) begin
      imm = ins & 32'h0FFF_FFFF;
      if (BR_SEXT != 0 && ((ins >> 27) & 1) == 1) imm = imm | 32'hF000_0000;
    end else if (ft == 0) imm = (ins >> 1) & 32'h7FFFF;
    else                  imm = (ins >> 20) & 32'hF;
    r.opa  = (ft == 3 || (ft == 0 && fc == 2)) ? 32'd0 : mread(src_a_of(ins), pc);
    r.opb  = (ins % 2 == 1) ? imm : mread(rx, pc);
    r.str  = mread(rd, pc);
    r.pc   = pc;
    r.rd   = 4'(rd);
    r.ft   = 2'(ft);
    r.fc   = 2'(fc);
    r.ctrl = {((ft == 0 && fc != 3) || (ft == 1 && fc == 0) || ft == 2 || (ft == 3 && fc % 2 == 0)),
              (ft == 1 && fc == 0), (ft == 1 && fc == 1),
              (ft == 3 && fc == 1), (ft == 3 && fc == 2), (ft == 2)};
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) regs[i] = '0;
    e         = '0;
    exp_valid = 1'b0;
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs
  task automatic cycle();
    logic hz_e, ir_e, acc, nv;
    #1;
    hz_e = exp_valid && e.ctrl[4] && in_valid &&
           ((int'(e.rd) == src_a_of(instr)) || (!instr[0] && e.rd == instr[19:16]));
    ir_e = (!exp_valid || out_ready) && !hz_e;
    chk("hazard", 64'(hazard), 64'(hz_e));
    chk("in_ready", 64'(in_ready), 64'(ir_e));
    acc = in_valid && ir_e && !flush;
    nv  = !flush && (acc || (exp_valid && !out_ready));
    if (acc) e = model_decode(instr, pc_in);
    if (wb_we) regs[wb_addr] = wb_data;
    @(posedge clk);
    #1;
    exp_valid = nv;
    chk("out_valid", 64'(out_valid), 64'(exp_valid));
    if (exp_valid) begin
      chk("opa", 64'(opa), 64'(e.opa));
      chk("opb", 64'(opb), 64'(e.opb));
      chk("str_data", 64'(str_data), 64'(e.str));
      chk("pc_out", 64'(pc_out), 64'(e.pc));
      chk("ctl", 64'({rd_out, funtype, funcode, sel_wb, sel_memrd, sel_memwr,
                      sel_cachewr, sel_cachesh, sel_branch}),
                 64'({e.rd, e.ft, e.fc, e.ctrl}));
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic ordy,
                       input logic we, input logic [3:0] wa, input logic [31:0] wd);
    in_valid  = v;
    instr     = ins;
    out_ready = ordy;
    wb_we     = we;
    wb_addr   = wa;
    wb_data   = wd;
    pc_in     = pc_in + 32'd4;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instr = '0; pc_in = 32'h100; wb_we = 1'b0;
    wb_addr = '0; wb_data = '0; flush = 1'b0; out_ready = 1'b0;
    model_reset();
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(opa | opb | str_data | pc_out), 64'd0);
    chk("rst_ctl", 64'({rd_out, funtype, funcode, sel_wb, sel_memrd, sel_memwr,
                        sel_cachewr, sel_cachesh, sel_branch}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Preload R2=5, R0=3, then reg ADD r1,r2,r0
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'd2, 32'd5);   cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'd0, 32'd3);   cycle();
    drive(1'b1, 32'h0120_0000, 1'b1, 1'b0, 4'd0, 32'd0); cycle();
    chk("add_opa", 64'(opa), 64'd5);
    chk("add_opb", 64'(opb), 64'd3);
    chk("add_wb", 64'(sel_wb), 64'd1);

    // MOV immediate
    drive(1'b1, 32'h2300_000B, 1'b1, 1'b0, 4'd0, 32'd0); cycle();
    chk("mov_opa", 64'(opa), 64'd0);
    chk("mov_opb", 64'(opb), 64'd5);
    chk("mov_rd", 64'(rd_out), 64'd3);

    // Load r4 followed by a consumer of r4: one bubble, then accept
    drive(1'b1, 32'h4400_0001, 1'b1, 1'b0, 4'd0, 32'd0); cycle();
    drive(1'b1, 32'h0040_0000, 1'b1, 1'b0, 4'd0, 32'd0);
    #1;
    chk("lu_hazard", 64'(hazard), 64'd1);
    chk("lu_in_ready", 64'(in_ready), 64'd0);
    cycle();
    chk("lu_bubble", 64'(out_valid), 64'd0);
    cycle();
    chk("lu_accept", 64'(out_valid), 64'd1);

    // Back-pressure for three cycles, then flush
    held = opa;
    drive(1'b1, 32'h1234_5678, 1'b0, 1'b0, 4'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_hold", 64'(opa), 64'(held));
    end
    flush = 1'b1; cycle(); flush = 1'b0;
    chk("flush_kill", 64'(out_valid), 64'd0);

    // Same-cycle writeback of r2 while decoding a read of r2
    drive(1'b1, 32'h0120_0000, 1'b1, 1'b1, 4'd2, 32'hAA); cycle();
`ifdef DECODE_FWD_EN
    chk("fwd_opa", 64'(opa), 64'hAA);
`else
    chk("nofwd_opa", 64'(opa), 64'd5);
`endif

    // Kernel cache-shoot and sign-extended branch
    drive(1'b1, 32'hE000_0000, 1'b1, 1'b0, 4'd0, 32'd0); cycle();
    chk("ker_cachesh", 64'({sel_cachesh, sel_wb}), 64'b11);
    chk("ker_opa", 64'(opa), 64'd0);
    drive(1'b1, 32'hBFFF_FFFF, 1'b1, 1'b0, 4'd0, 32'd0); cycle();
    chk("br_opb", 64'(opb), 64'hFFFF_FFFF);

    // Randomized traffic with biased load/use mixes
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      wb_we     = ($urandom_range(0, 1) == 1);
      wb_addr   = 4'($urandom_range(0, 15));
      wb_data   = $urandom;
      pc_in     = $urandom;
      instr     = $urandom;
      if ($urandom_range(0, 3) == 0) instr[31:28] = 4'b0100;
      if ($urandom_range(0, 3) == 0) instr[23:20] = 4'($urandom_range(3, 5));
      cycle();
    end
    flush = 1'b0;

    // Asynchronous reset in mid-cycle, then release away from the edge
    drive(1'b1, 32'h0120_0000, 1'b1, 1'b0, 4'd0, 32'd0); cycle();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_opa", 64'(opa | opb | pc_out), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b1, 32'h0120_0000, 1'b1, 1'b0, 4'd0, 32'd0); cycle();
    chk("arst_regs_cleared", 64'(opa), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter WIDTH, 32, datapath width of operands, PC and writeback data (>=28).
REQ-002 Parameter NREGS, 16, register-file entries; address width fixed at 4 bits by encoding.
REQ-003 Parameter PC_REG, 14, register index returned as register-sourced PC.
REQ-004 Parameter BR_SEXT, 0, 1 = branch Imm28 sign-extended from bit 27, 0 = zero-extended.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 in_valid  in  1  / in_ready  out  1  fetch-side handshake.
REQ-008 instr  in  32  / pc_in  in  WIDTH  instruction and its PC.
REQ-009 wb_we  in  1 / wb_addr  in  4 / wb_data  in  WIDTH  register writeback port.
REQ-010 flush  in  1  kill stage contents (taken branch).
REQ-011 out_valid  out  1  / out_ready  in  1  execute-side handshake.
REQ-012 opa, opb, str_data, pc_out  out  WIDTH  registered operands, store data, PC.
REQ-013 rd_out  out  4 / funtype, funcode  out  2 each  registered destination and opcode.
REQ-014 sel_wb, sel_memrd, sel_memwr, sel_cachewr, sel_cachesh, sel_branch  out  1 each  registered controls.
REQ-015 hazard  out  1  load-use stall indicator, combinational.

Function
REQ-016 Fields: funtype=[31:30], funcode=[29:28], rd=[27:24], rs=[23:20], rx=[19:16], selimm=[0]; Imm4=[23:20], Imm19=[19:1], Imm28=[27:0], zero-extended to WIDTH except REQ-004.
REQ-017 Immediate: branch (10) Imm28; reg (00) Imm19; else Imm4; opb = selimm ? Imm : R[rx].
REQ-018 Reg CMP (00/11): no writeback, source A read from rd; all other types read rs.
REQ-019 opa forced 0 for MOV (00/10) and all kernel (11) ops.
REQ-020 sel_wb = reg non-CMP | mem funcode 00 | branch | kernel funcode[0]=0; sel_memrd = mem/00; sel_memwr = mem/01; sel_cachewr = kernel/01; sel_cachesh = kernel/10; sel_branch = branch.
REQ-021 States: EMPTY (out_valid=0), FULL (out_valid=1), HAZARD (bubble pending); latency exactly one cycle instr->outputs.
REQ-022 EMPTY: in_valid&in_ready loads -> FULL. FULL: out_ready&~in_valid -> EMPTY; out_ready&accept -> FULL with new data; ~out_ready holds all outputs stable.
REQ-023 in_ready = (~out_valid | out_ready) & ~hazard.
REQ-024 hazard = out_valid & sel_memrd & in_valid & (rd_out equals instr's source-A reg, or rx when selimm=0); FULL->HAZARD on out_ready, emitting out_valid=0 one cycle, then HAZARD->EMPTY with input accepted that cycle.
REQ-025 flush: out_valid=0 next cycle, in-flight input discarded, state->EMPTY; flush wins over accept, hazard and hold.
REQ-026 Register file write synchronous on wb_we; read asynchronous; writes to any index including PC_REG allowed.
REQ-027 pc_out = pc_in of the accepted instruction; str_data = R[rd].

Reset
REQ-028 rst_n low: state EMPTY, out_valid=0, all data/control outputs 0, all registers 0, immediately and regardless of clk.
REQ-029 Reset release mid-handshake: first accept no earlier than first rising edge with rst_n high.

Configuration
REQ-030 DECODE_FWD_EN defined: a read whose address equals wb_addr while wb_we=1 returns wb_data same cycle (write-through bypass).
REQ-031 DECODE_FWD_EN undefined: same-cycle read returns pre-write value; ports unchanged.

Structure
REQ-032 Package decode_pkg: funtype enum (REG, MEM, BRANCH, KERNEL), funcode constants, field bit positions, state enum.
REQ-033 One sub-module decode_regfile (NREGS x WIDTH, 2 read ports plus store-data port, 1 write port, async read, bypass under DECODE_FWD_EN).

Verification
REQ-034 Reset then instr 0x0120_0000 (reg ADD r1,r2,r0), R2=5, R0=3 -> next cycle out_valid=1, opa=5, opb=3, sel_wb=1.
REQ-035 MOV imm: instr 0x2300_000B -> opa=0, opb=5 (Imm19), rd_out=3, sel_wb=1.
REQ-036 Load r4 in FULL, next instr reads r4, out_ready=1 -> hazard=1, one bubble cycle out_valid=0, then instr accepted.
REQ-037 out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0; flush asserted -> out_valid=0 next cycle.
REQ-038 wb_we=1, wb_addr=2, wb_data=0xAA while decoding read of r2 -> opa=0xAA with DECODE_FWD_EN, old value without.
REQ-039 Kernel funcode 10 -> sel_cachesh=1, sel_wb=1, opa=0; branch 0xBFFF_FFFF with BR_SEXT=1 -> opb=0xFFFF_FFFF.
